// File: rtl/map_pkg.sv
// Shared map definitions: cell width, wall IDs, server state encoding and the
// border pattern written by the post-reset init sweep.
package map_pkg;

  localparam int MAP_CELL_BITS = 2;

  typedef logic [MAP_CELL_BITS-1:0] cell_t;

  localparam cell_t WALL_NONE   = 2'd0;
  localparam cell_t WALL_LBLUE  = 2'd1;
  localparam cell_t WALL_BLUE   = 2'd2;
  localparam cell_t WALL_PURPLE = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } map_state_e;

  // Border cells become light-blue walls, the interior is empty.
  function automatic cell_t init_cell(input int unsigned col, input int unsigned row,
                                      input int unsigned col_max, input int unsigned row_max);
    if (col == 0 || col == col_max || row == 0 || row == row_max)
      return WALL_LBLUE;
    return WALL_NONE;
  endfunction

endpackage

// File: rtl/map_server_if.sv
// Map-cell access bundle: overlay pixel read, tracer req/ack read, host write, busy.
interface map_server_if #(
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4
);
  import map_pkg::*;

  logic [MAP_WBITS-1:0] ovl_col;
  logic [MAP_HBITS-1:0] ovl_row;
  cell_t                ovl_val;

  logic                 trc_req;
  logic [MAP_WBITS-1:0] trc_col;
  logic [MAP_HBITS-1:0] trc_row;
  logic                 trc_ack;
  cell_t                trc_val;

  logic                 wr_en;
  logic [MAP_WBITS-1:0] wr_col;
  logic [MAP_HBITS-1:0] wr_row;
  cell_t                wr_val;

  logic                 busy;

  modport master (
    output ovl_col, ovl_row, trc_req, trc_col, trc_row, wr_en, wr_col, wr_row, wr_val,
    input  ovl_val, trc_ack, trc_val, busy
  );

  modport slave (
    input  ovl_col, ovl_row, trc_req, trc_col, trc_row, wr_en, wr_col, wr_row, wr_val,
    output ovl_val, trc_ack, trc_val, busy
  );

endinterface

// File: rtl/map_cell_array.sv
// Un-reset cell storage with one write port, one combinational read port and
// one registered read port (registered output is reset to WALL_NONE).
module map_cell_array import map_pkg::*; #(
  parameter int ABITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  cell_t            wdata,
  input  logic [ABITS-1:0] caddr,
  output cell_t            cdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output cell_t            rdata
);

  localparam int DEPTH = 2**ABITS;

  cell_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign cdata = mem[caddr];

  // Samples the array before a same-edge write lands, so collisions return old data.
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= WALL_NONE;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/map_server.sv
// Map responder: init sweep after reset, then serves tracer/overlay reads and host writes.
//   state   | meaning
//   ST_INIT | sweep writes border pattern to every cell, busy high, requests held off
//   ST_RUN  | tracer reads acked every other cycle, host writes accepted
module map_server import map_pkg::*; #(
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  map_server_if.slave  bus
);

  localparam int          ABITS   = MAP_WBITS + MAP_HBITS;
  localparam int unsigned COL_MAX = (2**MAP_WBITS) - 1;
  localparam int unsigned ROW_MAX = (2**MAP_HBITS) - 1;

  map_state_e           state_q, state_d;
  logic [ABITS-1:0]     ctr_q, ctr_d;
  logic                 ack_q;
  logic                 serve;
  logic                 busy;
  logic                 arr_we;
  logic [ABITS-1:0]     arr_waddr;
  cell_t                arr_wdata;
  cell_t                ovl_raw;
  logic [MAP_WBITS-1:0] sweep_col;
  logic [MAP_HBITS-1:0] sweep_row;

  assign sweep_col = ctr_q[MAP_WBITS-1:0];
  assign sweep_row = ctr_q[ABITS-1:MAP_WBITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ctr_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ack_q   <= serve;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    serve     = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = {bus.wr_row, bus.wr_col};
    arr_wdata = bus.wr_val;
    case (state_q)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_waddr = ctr_q;
        arr_wdata = init_cell(32'(sweep_col), 32'(sweep_row), COL_MAX, ROW_MAX);
        ctr_d     = ctr_q + ABITS'(1);
        if (&ctr_q)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        arr_we = bus.wr_en;
        // A request still high during its own ack cycle is not served again.
        serve  = bus.trc_req && !ack_q;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign busy        = (state_q == ST_INIT);
  assign bus.busy    = busy;
  assign bus.trc_ack = ack_q;
  assign bus.ovl_val = busy ? WALL_NONE : ovl_raw;

  map_cell_array #(.ABITS(ABITS)) u_cells (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .caddr ({bus.ovl_row, bus.ovl_col}),
    .cdata (ovl_raw),
    .re    (serve),
    .raddr ({bus.trc_row, bus.trc_col}),
    .rdata (bus.trc_val)
  );

endmodule
